// File: rtl/led_pkg.sv
// Shared definitions for the board LED drivers: the breathing PWM driver and
// the square-wave blinker both take their defaults from here.
package led_pkg;

  localparam int BOARD_CLOCK_HZ = 100_000_000;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_UP      = 3'd1,
    ST_HOLD_HI = 3'd2,
    ST_DOWN    = 3'd3,
    ST_HOLD_LO = 3'd4
  } breathe_state_t;

  // Width of a counter holding 0..n-1, never narrower than one bit.
  function automatic int cnt_width(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/led_breathe_pwm_out.sv
// PWM comparator for the breathing LED: free-running counter with period
// 2^N-1 so that duty 0 is always off and duty 2^N-1 is always on.
module pwm_out #(
  parameter int PWM_BITS = 8
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                en,
  input  logic [PWM_BITS-1:0] duty,
  output logic                led
);

  localparam logic [PWM_BITS-1:0] PWM_LAST = PWM_BITS'((2 ** PWM_BITS) - 2);
  localparam logic [PWM_BITS-1:0] PWM_ONE  = PWM_BITS'(1);

  logic [PWM_BITS-1:0] pwm_cnt_r;
  logic                led_r;
  logic                led_next_s;

  // Compare against the current duty; the result is registered below.
  always_comb begin
    led_next_s = 1'b0;
    if (en && (pwm_cnt_r < duty)) begin
      led_next_s = 1'b1;
    end else begin
      led_next_s = 1'b0;
    end
  end

  // Counter wraps one short of all-ones; output register keeps the pin glitch-free.
  always_ff @(posedge clock) begin
    if (reset) begin
      pwm_cnt_r <= '0;
      led_r     <= 1'b0;
    end else begin
      if (pwm_cnt_r == PWM_LAST) begin
        pwm_cnt_r <= '0;
      end else begin
        pwm_cnt_r <= pwm_cnt_r + PWM_ONE;
      end
      led_r <= led_next_s;
    end
  end

  assign led = led_r;

endmodule

// File: rtl/led_breathe.sv
// Breathing LED driver: step prescaler and brightness FSM ramp the duty up,
// hold, ramp down and hold; pwm_out turns the duty into the LED waveform.
module led_breathe
  import led_pkg::*;
#(
  parameter int CLOCK_FREQ = BOARD_CLOCK_HZ,
  parameter int STEP_HZ    = 512,
  parameter int PWM_BITS   = 8,
  parameter int HOLD_STEPS = 64
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                enable,
  output logic                led,
  output logic [PWM_BITS-1:0] duty,
  output logic [2:0]          phase
);

  localparam int DIV    = CLOCK_FREQ / STEP_HZ;
  localparam int PRE_W  = cnt_width(DIV);
  localparam int HOLD_W = cnt_width(HOLD_STEPS);

  localparam logic [PRE_W-1:0]    PRE_LAST  = PRE_W'(DIV - 1);
  localparam logic [PRE_W-1:0]    PRE_ONE   = PRE_W'(1);
  localparam logic [HOLD_W-1:0]   HOLD_LAST = HOLD_W'((HOLD_STEPS > 0) ? HOLD_STEPS - 1 : 0);
  localparam logic [HOLD_W-1:0]   HOLD_ONE  = HOLD_W'(1);
  localparam logic [PWM_BITS-1:0] DUTY_MAX  = {PWM_BITS{1'b1}};
  localparam logic [PWM_BITS-1:0] DUTY_ONE  = PWM_BITS'(1);
  localparam logic [PWM_BITS-1:0] DUTY_PEAK = DUTY_MAX - DUTY_ONE;
  localparam bit                  NO_HOLD   = (HOLD_STEPS == 0);

  breathe_state_t      state_r;
  logic [PRE_W-1:0]    pre_cnt_r;
  logic [HOLD_W-1:0]   hold_r;
  logic [PWM_BITS-1:0] duty_r;
  logic                step_s;
  logic                pwm_en_s;

  assign step_s   = (state_r != ST_IDLE) && (pre_cnt_r == PRE_LAST);
  // Gating on enable too makes the LED drop on the same edge the FSM goes idle.
  assign pwm_en_s = enable && (state_r != ST_IDLE);

  // Step prescaler: idles at zero so the first step lands DIV clocks into UP.
  always_ff @(posedge clock) begin
    if (reset) begin
      pre_cnt_r <= '0;
    end else if (!enable || (state_r == ST_IDLE)) begin
      pre_cnt_r <= '0;
    end else if (pre_cnt_r == PRE_LAST) begin
      pre_cnt_r <= '0;
    end else begin
      pre_cnt_r <= pre_cnt_r + PRE_ONE;
    end
  end

  // Brightness FSM; transitions on the peak/floor step keep duty from wrapping.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_r <= ST_IDLE;
      duty_r  <= '0;
      hold_r  <= '0;
    end else if (!enable) begin
      state_r <= ST_IDLE;
      duty_r  <= '0;
      hold_r  <= '0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          state_r <= ST_UP;
          duty_r  <= '0;
          hold_r  <= '0;
        end
        ST_UP: begin
          if (step_s) begin
            duty_r <= duty_r + DUTY_ONE;
            if (duty_r == DUTY_PEAK) begin
              hold_r  <= '0;
              state_r <= NO_HOLD ? ST_DOWN : ST_HOLD_HI;
            end else begin
              state_r <= ST_UP;
            end
          end else begin
            state_r <= ST_UP;
          end
        end
        ST_HOLD_HI: begin
          if (step_s) begin
            if (hold_r == HOLD_LAST) begin
              hold_r  <= '0;
              state_r <= ST_DOWN;
            end else begin
              hold_r  <= hold_r + HOLD_ONE;
            end
          end else begin
            state_r <= ST_HOLD_HI;
          end
        end
        ST_DOWN: begin
          if (step_s) begin
            duty_r <= duty_r - DUTY_ONE;
            if (duty_r == DUTY_ONE) begin
              hold_r  <= '0;
              state_r <= NO_HOLD ? ST_UP : ST_HOLD_LO;
            end else begin
              state_r <= ST_DOWN;
            end
          end else begin
            state_r <= ST_DOWN;
          end
        end
        ST_HOLD_LO: begin
          if (step_s) begin
            if (hold_r == HOLD_LAST) begin
              hold_r  <= '0;
              state_r <= ST_UP;
            end else begin
              hold_r  <= hold_r + HOLD_ONE;
            end
          end else begin
            state_r <= ST_HOLD_LO;
          end
        end
        default: begin
          state_r <= ST_IDLE;
          duty_r  <= '0;
          hold_r  <= '0;
        end
      endcase
    end
  end

  pwm_out #(
    .PWM_BITS (PWM_BITS)
  ) u_pwm_out (
    .clock (clock),
    .reset (reset),
    .en    (pwm_en_s),
    .duty  (duty_r),
    .led   (led)
  );

  assign duty  = duty_r;
  assign phase = state_r;

endmodule

// File: tb/tb_led_breathe.sv
// Bench for led_breathe: two instances (HOLD_STEPS=2 and 0) checked against a
// step-count reference model, a vector table and hand-written corner sequences.
module tb_led_breathe;

  localparam int DIV  = 8;
  localparam int DMAX = 7;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       en  = 1'b0;
  logic       led_a, led_b;
  logic [2:0] duty_a, duty_b, phase_a, phase_b;

  led_breathe #(.CLOCK_FREQ(64), .STEP_HZ(8), .PWM_BITS(3), .HOLD_STEPS(2)) dut (
    .clock(clk), .reset(rst), .enable(en), .led(led_a), .duty(duty_a), .phase(phase_a));

  led_breathe #(.CLOCK_FREQ(64), .STEP_HZ(8), .PWM_BITS(3), .HOLD_STEPS(0)) dut0 (
    .clock(clk), .reset(rst), .enable(en), .led(led_b), .duty(duty_b), .phase(phase_b));

  always #5 clk = ~clk;

  int n_cmp  = 0;
  int n_fail = 0;

  // Reference model: brightness is a closed-form function of steps since UP.
  bit m_act[2];
  int m_t[2];
  int m_steps[2];
  bit m_led[2];
  int m_pwm = 0;

  typedef struct {
    bit rst;
    bit en;
    int led;
    int duty;
    int phase;
  } vec_t;
  vec_t tbl[13];

  int led_h[0:160], duty_h[0:160], ph_h[0:160], duty0_h[0:160], ph0_h[0:160];

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic void derive(input int i, output int d, output int ph);
    int h, per, pos;
    h = (i == 0) ? 2 : 0;
    if (!m_act[i]) begin
      d = 0; ph = 0;
    end else begin
      per = 2 * (DMAX + h);
      pos = m_steps[i] % per;
      if (pos < DMAX) begin
        d = pos; ph = 1;
      end else if (pos < DMAX + h) begin
        d = DMAX; ph = 2;
      end else if (pos < 2 * DMAX + h) begin
        d = DMAX - (pos - DMAX - h); ph = 3;
      end else begin
        d = 0; ph = 4;
      end
    end
  endfunction

  task automatic model_edge();
    int d, ph;
    for (int i = 0; i < 2; i++) begin
      derive(i, d, ph);
      if (rst) begin
        m_act[i] = 0; m_t[i] = 0; m_steps[i] = 0; m_led[i] = 0;
      end else begin
        m_led[i] = en && m_act[i] && (m_pwm < d);
        if (!en) begin
          m_act[i] = 0; m_t[i] = 0; m_steps[i] = 0;
        end else if (!m_act[i]) begin
          m_act[i] = 1; m_t[i] = 0; m_steps[i] = 0;
        end else begin
          m_t[i]++;
          if (m_t[i] % DIV == 0) m_steps[i]++;
        end
      end
    end
    m_pwm = rst ? 0 : (m_pwm + 1) % DMAX;
  endtask

  task automatic check_models();
    int d, ph;
    for (int i = 0; i < 2; i++) begin
      derive(i, d, ph);
      chk($sformatf("model_led[%0d]", i),   (i == 0) ? int'(led_a) : int'(led_b), int'(m_led[i]));
      chk($sformatf("model_duty[%0d]", i),  (i == 0) ? int'(duty_a) : int'(duty_b), d);
      chk($sformatf("model_phase[%0d]", i), (i == 0) ? int'(phase_a) : int'(phase_b), ph);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
    #1;
    check_models();
  endtask

  // Reset, then enable: returns just after the edge that entered UP (k=0).
  task automatic restart();
    rst = 1'b1; en = 1'b0;
    tick();
    rst = 1'b0; en = 1'b1;
    tick();
  endtask

  initial begin
    int cnt;

    // Vector table: reset, idle, entry to UP, first step, reset with enable high.
    tbl[0] = '{1'b1, 1'b0, 0, 0, 0};
    tbl[1] = '{1'b0, 1'b0, 0, 0, 0};
    tbl[2] = '{1'b0, 1'b1, 0, 0, 1};
    for (int i = 3; i <= 9; i++) tbl[i] = '{1'b0, 1'b1, 0, 0, 1};
    tbl[10] = '{1'b0, 1'b1, 0, 1, 1};
    tbl[11] = '{1'b1, 1'b1, 0, 0, 0};
    tbl[12] = '{1'b0, 1'b1, 0, 0, 1};
    for (int i = 0; i < 13; i++) begin
      rst = tbl[i].rst; en = tbl[i].en;
      tick();
      chk($sformatf("tbl_led[%0d]", i), led_a, tbl[i].led);
      chk($sformatf("tbl_duty[%0d]", i), duty_a, tbl[i].duty);
      chk($sformatf("tbl_phase[%0d]", i), phase_a, tbl[i].phase);
    end

    // Reset then 50 idle clocks.
    rst = 1'b1; en = 1'b0;
    tick();
    rst = 1'b0;
    for (int k = 0; k < 50; k++) begin
      tick();
      chk("idle_out", int'(led_a) + int'(duty_a) + int'(phase_a), 0);
    end

    // One full breathe cycle on both instances.
    restart();
    for (int k = 0; k <= 160; k++) begin
      if (k > 0) tick();
      led_h[k] = led_a; duty_h[k] = duty_a; ph_h[k] = phase_a;
      duty0_h[k] = duty_b; ph0_h[k] = phase_b;
    end
    chk("up_entry_phase", ph_h[0], 1);
    chk("first_step_pre", duty_h[7], 0);
    chk("first_step", duty_h[8], 1);
    chk("up_before_peak", duty_h[55], 6);
    chk("peak_duty", duty_h[56], 7);
    chk("peak_phase", ph_h[56], 2);
    chk("hold_hi_end", ph_h[71], 2);
    chk("down_entry", ph_h[72], 3);
    chk("down_last", duty_h[127], 1);
    chk("hold_lo_entry", ph_h[128], 4);
    chk("hold_lo_duty", duty_h[128], 0);
    chk("hold_lo_end", ph_h[143], 4);
    chk("period_wrap", ph_h[144], 1);
    cnt = 0;
    for (int k = 25; k <= 31; k++) cnt += led_h[k];
    chk("duty3_on_count", cnt, 3);
    cnt = 0;
    for (int k = 57; k <= 80; k++) cnt += led_h[k];
    chk("duty7_on_count", cnt, 24);
    cnt = 0;
    for (int k = 129; k <= 152; k++) cnt += led_h[k];
    chk("duty0_on_count", cnt, 0);
    chk("nohold_peak_phase", ph0_h[56], 3);
    chk("nohold_peak_duty", duty0_h[56], 7);
    chk("nohold_next_duty", duty0_h[64], 6);
    chk("nohold_wrap_phase", ph0_h[112], 1);
    chk("nohold_wrap_duty", duty0_h[112], 0);
    cnt = 0;
    for (int k = 0; k <= 160; k++) if (ph0_h[k] != 1 && ph0_h[k] != 3) cnt++;
    chk("nohold_bad_phases", cnt, 0);

    // Drop enable on the step cycle at duty 4, then re-enable.
    restart();
    for (int k = 1; k <= 39; k++) tick();
    chk("drop_pre_duty", duty_a, 4);
    en = 1'b0;
    tick();
    chk("drop_phase", phase_a, 0);
    chk("drop_duty", duty_a, 0);
    chk("drop_led", led_a, 0);
    en = 1'b1;
    tick();
    chk("reen_phase", phase_a, 1);
    for (int k = 1; k <= 7; k++) tick();
    chk("reen_pre_step", duty_a, 0);
    tick();
    chk("reen_step", duty_a, 1);

    // One-clock reset in HOLD_HI with enable held high.
    restart();
    for (int k = 1; k <= 60; k++) tick();
    chk("rst_pre_phase", phase_a, 2);
    rst = 1'b1;
    tick();
    chk("rst_phase", phase_a, 0);
    chk("rst_duty", duty_a, 0);
    chk("rst_led", led_a, 0);
    rst = 1'b0;
    tick();
    chk("rst_resume_phase", phase_a, 1);
    chk("rst_resume_duty", duty_a, 0);

    // Random enable/reset activity against the model.
    for (int k = 0; k < 4000; k++) begin
      if ($urandom_range(0, 199) == 0) en = ~en;
      rst = ($urandom_range(0, 399) == 0);
      tick();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/led_breathe.md
# led_breathe

PWM "breathing" LED driver that sits directly downstream of the board clock, alongside the square-wave blinker. It drives the same single LED pin. Instead of a hard on/off, it ramps brightness smoothly up, holds, ramps down and holds, using a step prescaler, a brightness state machine and a PWM comparator. Top level selects either this block or the blinker onto `led`.

## Interface

Parameters:
- `CLOCK_FREQ`, default 100_000_000: input clock frequency in Hz.
- `STEP_HZ`, default 512: brightness steps per second. Requires `CLOCK_FREQ/STEP_HZ >= 2`.
- `PWM_BITS`, default 8: duty resolution N.
- `HOLD_STEPS`, default 64: steps spent at full and at zero brightness. 0 skips both hold states.

Ports (clock, reset first):
- `clock` input 1: single clock, all logic on its rising edge.
- `reset` input 1: synchronous, active-high.
- `enable` input 1: level. Low forces IDLE.
- `led` output 1: registered PWM output.
- `duty` output PWM_BITS: current brightness.
- `phase` output 3: current state encoding.

## Operation

- Reset (sync, active-high): all registers cleared. After the reset edge: `led`=0, `duty`=0, `phase`=IDLE (0), prescaler=0, hold counter=0, PWM counter=0.
- Prescaler:
  - DIV = CLOCK_FREQ/STEP_HZ (integer division); width $clog2(DIV).
  - Counts 0..DIV-1 while state≠IDLE and wraps to 0.
  - `step` is a one-cycle internal pulse when count==DIV-1.
  - Held at 0 in IDLE.
- PWM counter:
  - Free-running 0..2^N-2, then wraps to 0 (period 2^N-1).
  - `led` <= (state≠IDLE) && (pwm_cnt < duty).
  - Result: duty 0 is always off; duty 2^N-1 is always on.
- State machine (phase encoding):
  - IDLE=0: `duty`=0. Go to UP in the cycle after `enable`=1 is sampled.
  - UP=1: on `step`, duty+1. On the step where duty becomes 2^N-1, go to HOLD_HI with hold counter cleared. If HOLD_STEPS==0, go directly to DOWN instead.
  - HOLD_HI=2: on `step`, hold counter +1. On the step where it reaches HOLD_STEPS, go to DOWN and clear the counter.
  - DOWN=3: on `step`, duty−1. On the step where duty becomes 0, go to HOLD_LO. If HOLD_STEPS==0, go directly to UP instead.
  - HOLD_LO=4: same as HOLD_HI, then go to UP.
- `enable` low in any state: the next edge goes to IDLE with `duty`=0, `led`=0 and prescaler cleared. This overrides a coincident `step`.
- `duty` never wraps; saturation is guaranteed by the transitions above.

## Timing

- Step period: DIV clocks. The first `step` after leaving IDLE occurs DIV clocks after entering UP.
- `duty` updates on the same edge that `step` is high. `led` reflects the new duty at the next compare, registered, so at most 1 clock behind the comparator.
- Full breathe period: 2·(2^N−1+HOLD_STEPS) steps. Defaults: 638 steps ≈ 1.246 s.
- `reset` has priority over `enable` and `step`. Reset mid-ramp yields IDLE outputs on the next edge.
- `led` is glitch-free (registered). No combinational path from input to output.

## Structure

- Shared package `led_pkg`:
  - state enum `breathe_state_t` (IDLE..HOLD_LO, 3 bits, encoding above).
  - board clock frequency constant, shared with the blinker.
- Sub-module `pwm_out`:
  - Parameter PWM_BITS.
  - Inputs: `clock`, `reset`, `en`, `duty`.
  - Output: `led`.
  - Contains the PWM counter and the output register.
- Top-level `led_breathe` holds the prescaler, hold counter and FSM.

## Test plan

Common bench parameters: CLOCK_FREQ=64, STEP_HZ=8 (DIV=8), PWM_BITS=3 (period 7), HOLD_STEPS=2.

1. Reset, `enable`=0 for 50 clocks -> `led`=0, `duty`=0, `phase`=0 throughout.
2. Raise `enable` -> `phase`=1 next clock; `duty` increments every 8 clocks to 7 (56 clocks); then `phase`=2 for 16 clocks, 3 (down to 0), 4 (16 clocks), back to 1. Total cycle 18 steps = 144 clocks.
3. Duty checks:
   - with `duty`=3: `led` high exactly 3 of each 7 clocks.
   - with `duty`=7: `led` constantly 1.
   - with `duty`=0: `led` constantly 0.
4. Drop `enable` mid-UP at `duty`=4, on a `step` cycle -> next clock `phase`=0, `duty`=0, `led`=0. Re-enable -> ramp restarts from 0, first step 8 clocks later.
5. Assert `reset` for 1 clock in HOLD_HI -> next clock all outputs zero and `phase`=0, even with `enable` held high. Resumes UP one clock after reset deasserts.
6. HOLD_STEPS=0 -> `phase` sequence 1→3→1 only; `duty` goes 7→6 on consecutive steps with no hold.
